// File: rtl/nubus_cpld_glue.sv
`default_nettype none
// =============================================================================
// nubus_cpld_glue : NuBus 5 V <-> 3.3 V control-line bridge with line-direction
// control, '145 driver steering and distributed arbitration for the card slot.
// Option macro: NUBUS_CPLD_TM2_EN (TM2 becomes FPGA-driveable like TM0/TM1).
// Revision: 1.0
// =============================================================================
module nubus_cpld_glue (
  input  logic       clk_n_5v,
  input  logic       reset_n_5v,
  input  logic       clk2x_n_5v,
  input  logic [3:0] id_n_5v,
  output logic       clk_n_3v3,
  output logic       clk2x_n_3v3,
  output logic       reset_n_3v3,
  output logic [3:0] id_n_3v3,
  input  logic       tm0_n_5v,
  input  logic       tm1_n_5v,
  input  logic       tm2_n_5v,
  input  logic       start_n_5v,
  input  logic       ack_n_5v,
  input  logic       rqst_n_5v,
  inout  wire        tm0_n_3v3,
  inout  wire        tm1_n_3v3,
  inout  wire        tm2_n_3v3,
  inout  wire        start_n_3v3,
  inout  wire        ack_n_3v3,
  output logic       rqst_n_3v3,
  output logic       tm0_o_n,
  output logic       tm1_o_n,
  output logic       tm2_o_n,
  output logic       start_o_n,
  output logic       ack_o_n,
  output logic       tmx_oe_n,
  output logic       tm2_oe_n,
  output logic       start_oe_n,
  output logic       ack_oe_n,
  output logic       rqst_o_n,
  input  logic [3:0] arb_n_5v,
  output logic [3:0] arb_o_n,
  input  logic       arbcy_n,
  output logic       grant,
  input  logic       nubus_oe,
  input  logic       tmoen,
  input  logic       nubus_master_dir,
  input  logic       fpga_to_cpld_clk,
  input  logic       fpga_to_cpld_signal,
  input  logic       fpga_to_cpld_signal_2
);

  logic       drv;
  logic       tm_fpga;
  logic       st_fpga;
  logic       req;
  logic [3:0] my_id;
  logic [3:0] bus_id;
  logic [3:0] outranked;
  logic [3:0] arb_drive;
  logic       grant_d;
  logic       grant_q;
  logic       unused_ok;

  assign clk_n_3v3   = clk_n_5v;
  assign clk2x_n_3v3 = clk2x_n_5v;
  assign reset_n_3v3 = reset_n_5v;
  assign id_n_3v3    = id_n_5v;
  assign rqst_n_3v3  = rqst_n_5v;

  // Reset forces every bus driver off regardless of what the FPGA requests.
  assign drv     = ~nubus_oe & reset_n_5v;
  assign tm_fpga = tmoen & drv;
  assign st_fpga = nubus_master_dir & drv;

  assign tm0_n_3v3   = tm_fpga ? 1'bz : tm0_n_5v;
  assign tm1_n_3v3   = tm_fpga ? 1'bz : tm1_n_5v;
  assign ack_n_3v3   = tm_fpga ? 1'bz : ack_n_5v;
  assign start_n_3v3 = st_fpga ? 1'bz : start_n_5v;

  assign tm0_o_n   = tm0_n_3v3;
  assign tm1_o_n   = tm1_n_3v3;
  assign ack_o_n   = ack_n_3v3;
  assign start_o_n = start_n_3v3;

  assign tmx_oe_n   = ~tm_fpga;
  assign ack_oe_n   = ~tm_fpga;
  assign start_oe_n = ~st_fpga;

`ifdef NUBUS_CPLD_TM2_EN
  assign tm2_n_3v3 = tm_fpga ? 1'bz : tm2_n_5v;
  assign tm2_o_n   = tm2_n_3v3;
  assign tm2_oe_n  = ~tm_fpga;
`else
  assign tm2_n_3v3 = tm2_n_5v;
  assign tm2_o_n   = 1'b1;
  assign tm2_oe_n  = 1'b1;
`endif

  assign my_id  = ~id_n_5v;
  assign bus_id = ~arb_n_5v;
  assign req    = ~arbcy_n & drv;

  // A bit where the bus shows 1 but our ID has 0 means a higher competitor.
  assign outranked = bus_id & ~my_id;

  genvar k;
  generate
    for (k = 0; k < 4; k++) begin : g_arb
      assign arb_drive[k] = req & my_id[k] & ((outranked >> (k + 1)) == 4'd0);
    end
  endgenerate

  assign arb_o_n  = ~arb_drive;
  assign rqst_o_n = ~req;

  assign grant_d = req & (arb_n_5v == id_n_5v);

  // Falling edge is the NuBus sampling edge.
  always_ff @(negedge clk_n_5v or negedge reset_n_5v) begin
    if (!reset_n_5v) begin
      grant_q <= 1'b0;
    end else begin
      grant_q <= grant_d;
    end
  end

  assign grant = grant_q;

  assign unused_ok = &{1'b0, fpga_to_cpld_clk, fpga_to_cpld_signal, fpga_to_cpld_signal_2};

endmodule
`default_nettype wire

// File: tb/tb_nubus_cpld_glue.sv
`default_nettype none
// tb_nubus_cpld_glue : table vectors, directed reset/grant sequences and random
// stimulus compared against a behavioural model of the bridge.
module tb_nubus_cpld_glue;

`ifdef NUBUS_CPLD_TM2_EN
  localparam bit TM2_EN = 1'b1;
`else
  localparam bit TM2_EN = 1'b0;
`endif

  // Line vectors: [0]=tm0 [1]=tm1 [2]=tm2 [3]=start [4]=ack
  typedef struct {
    logic       rst_n, oe, tmoen, mdir, arbcy_n, rqst5, clk2x;
    logic [3:0] id_n, arb_n;
    logic [4:0] bus5, fpga;
  } stim_t;

  typedef struct {
    logic [3:0] arb_o_n;
    logic       rqst_o_n;
    logic       grant;
    logic [3:0] oe_n;  // {tmx, tm2, start, ack}
    logic [4:0] pin;
    logic [4:0] o_n;
    logic [4:0] fpga_en;
  } exp_t;

  typedef struct {
    stim_t      s;
    logic [3:0] arb_o_n;
    logic       rqst_o_n;
    logic       grant;
    logic [3:0] oe_n;
  } vec_t;

  logic       clk_n_5v = 1'b0;
  logic       reset_n_5v, clk2x_n_5v, rqst_n_5v, arbcy_n, nubus_oe, tmoen, nubus_master_dir;
  logic [3:0] id_n_5v, arb_n_5v;
  logic [4:0] b5, fen, fval;

  logic       clk_n_3v3, clk2x_n_3v3, reset_n_3v3, rqst_n_3v3;
  logic [3:0] id_n_3v3, arb_o_n;
  logic       tm0_o_n, tm1_o_n, tm2_o_n, start_o_n, ack_o_n;
  logic       tmx_oe_n, tm2_oe_n, start_oe_n, ack_oe_n, rqst_o_n, grant;

  wire tm0_n_3v3, tm1_n_3v3, tm2_n_3v3, start_n_3v3, ack_n_3v3;
  assign tm0_n_3v3   = fen[0] ? fval[0] : 1'bz;
  assign tm1_n_3v3   = fen[1] ? fval[1] : 1'bz;
  assign tm2_n_3v3   = fen[2] ? fval[2] : 1'bz;
  assign start_n_3v3 = fen[3] ? fval[3] : 1'bz;
  assign ack_n_3v3   = fen[4] ? fval[4] : 1'bz;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vq[$];

  always #5 clk_n_5v = ~clk_n_5v;

  nubus_cpld_glue dut (
    .clk_n_5v(clk_n_5v), .reset_n_5v(reset_n_5v), .clk2x_n_5v(clk2x_n_5v), .id_n_5v(id_n_5v),
    .clk_n_3v3(clk_n_3v3), .clk2x_n_3v3(clk2x_n_3v3), .reset_n_3v3(reset_n_3v3), .id_n_3v3(id_n_3v3),
    .tm0_n_5v(b5[0]), .tm1_n_5v(b5[1]), .tm2_n_5v(b5[2]), .start_n_5v(b5[3]), .ack_n_5v(b5[4]),
    .rqst_n_5v(rqst_n_5v),
    .tm0_n_3v3(tm0_n_3v3), .tm1_n_3v3(tm1_n_3v3), .tm2_n_3v3(tm2_n_3v3),
    .start_n_3v3(start_n_3v3), .ack_n_3v3(ack_n_3v3), .rqst_n_3v3(rqst_n_3v3),
    .tm0_o_n(tm0_o_n), .tm1_o_n(tm1_o_n), .tm2_o_n(tm2_o_n), .start_o_n(start_o_n), .ack_o_n(ack_o_n),
    .tmx_oe_n(tmx_oe_n), .tm2_oe_n(tm2_oe_n), .start_oe_n(start_oe_n), .ack_oe_n(ack_oe_n),
    .rqst_o_n(rqst_o_n), .arb_n_5v(arb_n_5v), .arb_o_n(arb_o_n), .arbcy_n(arbcy_n), .grant(grant),
    .nubus_oe(nubus_oe), .tmoen(tmoen), .nubus_master_dir(nubus_master_dir),
    .fpga_to_cpld_clk(1'b0), .fpga_to_cpld_signal(1'b0), .fpga_to_cpld_signal_2(1'b0)
  );

  // Behavioural view: who sources each line, and which ID wins the bus.
  function automatic exp_t model(stim_t s);
    exp_t       e;
    logic       drive_ok, tm_f, st_f, tm2_f, req;
    logic [3:0] mine, bus, hi_mine, hi_bus;
    drive_ok = s.rst_n && !s.oe;
    tm_f     = drive_ok && s.tmoen;
    st_f     = drive_ok && s.mdir;
    tm2_f    = TM2_EN && tm_f;
    e.fpga_en = {tm_f, st_f, tm2_f, tm_f, tm_f};
    for (int i = 0; i < 5; i++) e.pin[i] = e.fpga_en[i] ? s.fpga[i] : s.bus5[i];
    e.o_n = e.pin;
    if (!TM2_EN) e.o_n[2] = 1'b1;
    e.oe_n = {!tm_f, !tm2_f, !st_f, !tm_f};
    req  = drive_ok && !s.arbcy_n;
    mine = ~s.id_n;
    bus  = ~s.arb_n;
    for (int k = 0; k < 4; k++) begin
      hi_mine = mine >> (k + 1);
      hi_bus  = bus >> (k + 1);
      // keep driving bit k only while the bus's upper bits are a subset of ours
      e.arb_o_n[k] = !(req && mine[k] && ((hi_bus | hi_mine) == hi_mine));
    end
    e.rqst_o_n = !req;
    e.grant    = req && (bus == mine);
    return e;
  endfunction

  function automatic stim_t mk(logic rst_n, logic oe, logic tmo, logic mdir, logic arbcy,
                               logic [3:0] id_n, logic [3:0] arb_n, logic [4:0] fpga);
    stim_t s;
    s.rst_n = rst_n; s.oe = oe; s.tmoen = tmo; s.mdir = mdir; s.arbcy_n = arbcy;
    s.id_n = id_n; s.arb_n = arb_n; s.fpga = fpga;
    s.bus5 = 5'b10101; s.rqst5 = 1'b1; s.clk2x = 1'b0;
    return s;
  endfunction

  task automatic add(stim_t s, logic [3:0] a, logic r, logic g, logic [3:0] o);
    vec_t v;
    v.s = s; v.arb_o_n = a; v.rqst_o_n = r; v.grant = g; v.oe_n = o;
    vq.push_back(v);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(stim_t s);
    exp_t e;
    e = model(s);
    reset_n_5v = s.rst_n; nubus_oe = s.oe; tmoen = s.tmoen; nubus_master_dir = s.mdir;
    arbcy_n = s.arbcy_n; id_n_5v = s.id_n; arb_n_5v = s.arb_n; b5 = s.bus5;
    rqst_n_5v = s.rqst5; clk2x_n_5v = s.clk2x; fval = s.fpga; fen = e.fpga_en;
  endtask

  task automatic check_comb(stim_t s, string tag);
    exp_t e;
    e = model(s);
    chk({tag, ":arb_o_n"}, 32'(arb_o_n), 32'(e.arb_o_n));
    chk({tag, ":rqst_o_n"}, 32'(rqst_o_n), 32'(e.rqst_o_n));
    chk({tag, ":oe_n"}, 32'({tmx_oe_n, tm2_oe_n, start_oe_n, ack_oe_n}), 32'(e.oe_n));
    chk({tag, ":pins"}, 32'({ack_n_3v3, start_n_3v3, tm2_n_3v3, tm1_n_3v3, tm0_n_3v3}), 32'(e.pin));
    chk({tag, ":o_n"}, 32'({ack_o_n, start_o_n, tm2_o_n, tm1_o_n, tm0_o_n}), 32'(e.o_n));
    chk({tag, ":passthru"}, 32'({clk_n_3v3, clk2x_n_3v3, reset_n_3v3, rqst_n_3v3, id_n_3v3}),
        32'({clk_n_5v, s.clk2x, s.rst_n, s.rqst5, s.id_n}));
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic apply(stim_t s, string tag);
    exp_t e;
    e = model(s);
    drive(s);
    #2;
    check_comb(s, tag);
    @(negedge clk_n_5v);
    #1;
    chk({tag, ":grant"}, 32'(grant), 32'(e.grant));
    @(posedge clk_n_5v);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    stim_t s;
    add(mk(0,0,1,0,0, 4'b0011, 4'b0011, 5'b00010), 4'b1111, 1'b1, 1'b0, 4'b1111);
    add(mk(1,0,1,0,1, 4'b0011, 4'b1111, 5'b01010), 4'b1111, 1'b1, 1'b0, {1'b0, !TM2_EN, 1'b1, 1'b0});
    add(mk(1,0,0,0,1, 4'b0011, 4'b1111, 5'b01010), 4'b1111, 1'b1, 1'b0, 4'b1111);
    add(mk(1,0,0,0,0, 4'b0011, 4'b0011, 5'b00000), 4'b0011, 1'b0, 1'b1, 4'b1111);
    add(mk(1,0,0,0,0, 4'b0110, 4'b0011, 5'b00000), 4'b0111, 1'b0, 1'b0, 4'b1111);
    add(mk(1,0,0,1,1, 4'b0011, 4'b1111, 5'b10010), 4'b1111, 1'b1, 1'b0, 4'b1101);
    add(mk(1,1,1,1,0, 4'b0011, 4'b0011, 5'b10010), 4'b1111, 1'b1, 1'b0, 4'b1111);
    add(mk(1,0,1,0,1, 4'b0011, 4'b1111, 5'b11011), 4'b1111, 1'b1, 1'b0, {1'b0, !TM2_EN, 1'b1, 1'b0});
    add(mk(1,0,0,0,0, 4'b0000, 4'b0000, 5'b00000), 4'b0000, 1'b0, 1'b1, 4'b1111);
    add(mk(1,0,0,0,0, 4'b1111, 4'b1111, 5'b00000), 4'b1111, 1'b0, 1'b1, 4'b1111);
    add(mk(1,0,0,0,0, 4'b0000, 4'b1111, 5'b00000), 4'b0000, 1'b0, 1'b0, 4'b1111);
    add(mk(1,0,0,0,0, 4'b0111, 4'b0000, 5'b00000), 4'b0111, 1'b0, 1'b0, 4'b1111);

    drive(vq[0].s);
    @(posedge clk_n_5v);
    #1;
    for (int i = 0; i < vq.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      apply(vq[i].s, tag);
      chk({tag, ":tbl_arb"}, 32'(arb_o_n), 32'(vq[i].arb_o_n));
      chk({tag, ":tbl_rqst"}, 32'(rqst_o_n), 32'(vq[i].rqst_o_n));
      chk({tag, ":tbl_grant"}, 32'(grant), 32'(vq[i].grant));
      chk({tag, ":tbl_oe"}, 32'({tmx_oe_n, tm2_oe_n, start_oe_n, ack_oe_n}), 32'(vq[i].oe_n));
    end

    // Reset in the middle of a won arbitration with all drivers enabled.
    s = mk(1,0,1,1,0, 4'b0011, 4'b0011, 5'b00000);
    apply(s, "seqA0");
    apply(s, "seqA1");
    chk("seqA:granted", 32'(grant), 32'd1);
    s.rst_n = 1'b0;
    drive(s);
    #1;
    chk("seqA:async_clear", 32'(grant), 32'd0);
    check_comb(s, "seqA:rst");
    @(negedge clk_n_5v);
    #1;
    chk("seqA:hold_in_rst", 32'(grant), 32'd0);
    chk("seqA:clk_lo", 32'(clk_n_3v3), 32'd0);
    @(posedge clk_n_5v);
    #1;
    chk("seqA:clk_hi", 32'(clk_n_3v3), 32'd1);
    s.rst_n = 1'b1;
    drive(s);
    #2;
    chk("seqA:no_early_grant", 32'(grant), 32'd0);
    @(negedge clk_n_5v);
    #1;
    chk("seqA:regrant", 32'(grant), 32'd1);
    @(posedge clk_n_5v);
    #1;

    // Request withdrawn: grant holds until the next falling edge, then drops.
    s.arbcy_n = 1'b1;
    drive(s);
    #2;
    chk("seqB:grant_held", 32'(grant), 32'd1);
    check_comb(s, "seqB");
    @(negedge clk_n_5v);
    #1;
    chk("seqB:grant_dropped", 32'(grant), 32'd0);
    @(posedge clk_n_5v);
    #1;

    // Losing card keeps competing but never wins.
    s = mk(1,0,0,0,0, 4'b0110, 4'b0011, 5'b00000);
    for (int i = 0; i < 3; i++) apply(s, $sformatf("seqC%0d", i));

    for (int i = 0; i < 400; i++) begin
      s.rst_n   = ($urandom_range(9) != 0);
      s.oe      = ($urandom_range(4) == 0);
      s.tmoen   = 1'($urandom);
      s.mdir    = 1'($urandom);
      s.arbcy_n = ($urandom_range(2) == 0);
      s.rqst5   = 1'($urandom);
      s.clk2x   = 1'($urandom);
      s.id_n    = 4'($urandom);
      s.arb_n   = ($urandom_range(2) == 0) ? s.id_n : 4'($urandom);
      s.bus5    = 5'($urandom);
      s.fpga    = 5'($urandom);
      apply(s, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
